// File: rtl/stream_mux_nto1_if.sv
// Handshake bundle for stream_mux_nto1: N producer streams in, one consumer stream out.
// The mux connects through the slave modport; producers and the consumer use master.
interface stream_mux_nto1_if #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic [SEL_W-1:0]   grant;
    logic               locked;

    modport master (
        output in_data, in_valid, in_last, sel, out_ready,
        input  in_ready, out_data, out_valid, out_last, grant, locked
    );

    modport slave (
        input  in_data, in_valid, in_last, sel, out_ready,
        output in_ready, out_data, out_valid, out_last, grant, locked
    );
endinterface

// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 stream mux with valid/ready handshake. A channel is locked for a
// whole packet (through its last beat), chosen by external select or round-robin.
module stream_mux_nto1 #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_mux_nto1_if.slave bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             pick_ok;
    logic [SEL_W-1:0] pick;
    logic             can_load;
    logic [N-1:0]     ready_c;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             in_fire;

    // Channel to lock when leaving IDLE. A select value of N or more never matches.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        pick_ok = 1'b0;
        pick    = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    pick_ok = 1'b1;
                    pick    = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                automatic int idx = (int'(rr_ptr_q) + k) % N;
                if (!pick_ok && bus.in_valid[idx]) begin
                    pick_ok = 1'b1;
                    pick    = SEL_W'(idx);
                end
            end
        end
    end

    // in_ready is a function of state and out_ready only, never of in_valid.
    always_comb begin
        can_load = !out_valid_q || bus.out_ready;
        ready_c  = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == SEL_W'(i)) begin
                ready_c[i] = (state_q == ST_LOCKED) && can_load;
                sel_data   = bus.in_data[i*WIDTH +: WIDTH];
                sel_last   = bus.in_last[i];
            end
        end
        in_fire = |(ready_c & bus.in_valid);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_ok) begin
                    grant_d = pick;
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                if (in_fire && sel_last) begin
                    rr_ptr_d = grant_q;
                    state_d  = ST_IDLE;
                end
            end
        endcase

        // A reload in the same cycle as an output accept keeps out_valid high: no gap.
        if (in_fire) begin
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples the values
    // from before the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= SEL_W'(N - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.grant     = grant_q;
    assign bus.locked    = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: one external-select and one round-robin instance fed by
// queue-driven producers; output beats are matched against an expected-beat scoreboard.
module tb_stream_mux_nto1;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stream_mux_nto1_if #(.WIDTH(4), .N(4)) bus0 ();
    stream_mux_nto1_if #(.WIDTH(4), .N(4)) bus1 ();

    stream_mux_nto1 #(.WIDTH(4), .N(4), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    stream_mux_nto1 #(.WIDTH(4), .N(4), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Beats are {last, data}.
    logic [4:0] src0 [4][$];
    logic [4:0] src1 [4][$];
    logic [4:0] exp0 [$];
    logic [4:0] exp1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Producers: present the head of each channel queue, pop it once accepted.
    initial begin
        logic [3:0] f;
        bus0.in_valid = '0;
        bus0.in_data  = '0;
        bus0.in_last  = '0;
        forever begin
            @(negedge clk);
            f = bus0.in_valid & bus0.in_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (f[c] && src0[c].size() > 0) void'(src0[c].pop_front());
                bus0.in_valid[c] = (src0[c].size() > 0);
                if (src0[c].size() > 0) begin
                    bus0.in_data[c*4 +: 4] = src0[c][0][3:0];
                    bus0.in_last[c]        = src0[c][0][4];
                end
            end
        end
    end

    initial begin
        logic [3:0] f;
        bus1.in_valid = '0;
        bus1.in_data  = '0;
        bus1.in_last  = '0;
        forever begin
            @(negedge clk);
            f = bus1.in_valid & bus1.in_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (f[c] && src1[c].size() > 0) void'(src1[c].pop_front());
                bus1.in_valid[c] = (src1[c].size() > 0);
                if (src1[c].size() > 0) begin
                    bus1.in_data[c*4 +: 4] = src1[c][0][3:0];
                    bus1.in_last[c]        = src1[c][0][4];
                end
            end
        end
    end

    // Monitors: every accepted output beat must be the next expected one.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus0.out_valid && bus0.out_ready) begin
            if (exp0.size() == 0) check("mon0_unexpected_beat", {bus0.out_last, bus0.out_data}, 32'hFF);
            else check("mon0_beat", {bus0.out_last, bus0.out_data}, exp0.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (exp1.size() == 0) check("mon1_unexpected_beat", {bus1.out_last, bus1.out_data}, 32'hFF);
            else check("mon1_beat", {bus1.out_last, bus1.out_data}, exp1.pop_front());
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 60) begin
            step();
            n++;
        end
        check("drain_pending_beats", exp0.size() + exp1.size(), 0);
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        bus0.sel       = '0;
        bus0.out_ready = 1'b0;
        bus1.sel       = '0;
        bus1.out_ready = 1'b0;
        repeat (3) step();
        check("rst_out_valid", {bus1.out_valid, bus0.out_valid}, 0);
        check("rst_out_data", {bus1.out_data, bus0.out_data}, 0);
        check("rst_out_last", {bus1.out_last, bus0.out_last}, 0);
        check("rst_locked", {bus1.locked, bus0.locked}, 0);
        check("rst_grant", {bus1.grant, bus0.grant}, 0);
        check("rst_in_ready", {bus1.in_ready, bus0.in_ready}, 0);
        rst_n = 1'b1;
        step();

        // Round robin, all channels valid, single-beat packets with data = channel+1.
        bus1.out_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                src1[c].push_back({1'b1, 4'(c + 1)});
                exp1.push_back({1'b1, 4'(c + 1)});
            end
        step();
        check("rr_c0_locked", bus1.locked, 0);
        check("rr_c0_in_ready", bus1.in_ready, 4'b0000);
        step();
        check("rr_c1_in_ready", bus1.in_ready, 4'b0001);
        step();
        check("rr_c2_out_valid", bus1.out_valid, 1);
        step();
        check("rr_c3_gap", bus1.out_valid, 0);
        check("rr_c3_in_ready", bus1.in_ready, 4'b0010);
        step();
        check("rr_c4_out_valid", bus1.out_valid, 1);
        drain();

        // External select of channel 2, single beat.
        bus0.sel       = 2'd2;
        bus0.out_ready = 1'b1;
        src0[2].push_back({1'b1, 4'hA});
        exp0.push_back({1'b1, 4'hA});
        step();
        check("sel2_c0_in_ready", bus0.in_ready, 4'b0000);
        step();
        check("sel2_c1_in_ready", bus0.in_ready, 4'b0100);
        check("sel2_c1_grant", bus0.grant, 2);
        step();
        check("sel2_c2_out", {bus0.out_valid, bus0.out_last, bus0.out_data}, {1'b1, 1'b1, 4'hA});
        check("sel2_c2_in_ready", bus0.in_ready, 4'b0000);
        drain();

        // Packet atomicity: ch1 holds the grant over ch0 until its last beat.
        src1[1].push_back({1'b0, 4'h5});
        src1[1].push_back({1'b0, 4'h6});
        src1[1].push_back({1'b1, 4'h7});
        exp1.push_back({1'b0, 4'h5});
        exp1.push_back({1'b0, 4'h6});
        exp1.push_back({1'b1, 4'h7});
        step();
        src1[0].push_back({1'b1, 4'h3});
        exp1.push_back({1'b1, 4'h3});
        step();
        check("atom_c2_in_ready", bus1.in_ready, 4'b0010);
        step();
        check("atom_c3_in_ready", bus1.in_ready, 4'b0010);
        check("atom_c3_out_valid", bus1.out_valid, 1);
        step();
        check("atom_c4_in_ready", bus1.in_ready, 4'b0010);
        check("atom_c4_out_valid", bus1.out_valid, 1);
        step();
        check("atom_c5_idle", bus1.locked, 0);
        check("atom_c5_out_valid", bus1.out_valid, 1);
        step();
        check("atom_c6_grant", {bus1.locked, bus1.grant}, {1'b1, 2'd0});
        drain();

        // Backpressure on ch0 for three cycles, then release.
        bus0.sel       = 2'd0;
        bus0.out_ready = 1'b0;
        src0[0].push_back({1'b0, 4'h6});
        src0[0].push_back({1'b0, 4'h7});
        src0[0].push_back({1'b1, 4'h8});
        exp0.push_back({1'b0, 4'h6});
        exp0.push_back({1'b0, 4'h7});
        exp0.push_back({1'b1, 4'h8});
        step();
        step();
        check("bp_load_in_ready", bus0.in_ready, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_out", {bus0.out_valid, bus0.out_data}, {1'b1, 4'h6});
            check("bp_hold_in_ready", bus0.in_ready, 4'b0000);
        end
        bus0.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", bus0.in_ready, 4'b0001);
        drain();

        // Select out of the valid set, then a select change in the middle of a packet.
        bus0.sel = 2'd3;
        src0[0].push_back({1'b1, 4'h9});
        step();
        step();
        check("sel3_no_grant", bus0.locked, 0);
        step();
        check("sel3_no_grant_later", {bus0.locked, bus0.in_ready}, 0);
        bus0.sel = 2'd2;
        src0[2].push_back({1'b0, 4'hB});
        src0[2].push_back({1'b0, 4'hC});
        src0[2].push_back({1'b1, 4'hD});
        exp0.push_back({1'b0, 4'hB});
        exp0.push_back({1'b0, 4'hC});
        exp0.push_back({1'b1, 4'hD});
        step();
        check("selchg_c1_idle", bus0.locked, 0);
        step();
        check("selchg_c2_grant", {bus0.locked, bus0.grant}, {1'b1, 2'd2});
        bus0.sel = 2'd0;
        exp0.push_back({1'b1, 4'h9});
        step();
        check("selchg_c3_keep", {bus0.grant, bus0.in_ready}, {2'd2, 4'b0100});
        step();
        check("selchg_c4_keep", {bus0.grant, bus0.in_ready}, {2'd2, 4'b0100});
        step();
        check("selchg_c5_idle", bus0.locked, 0);
        step();
        check("selchg_c6_grant", {bus0.locked, bus0.grant}, {1'b1, 2'd0});
        drain();

        // Reset with an output beat in flight, then channel 0 must win first.
        bus1.out_ready = 1'b0;
        src1[2].push_back({1'b0, 4'h1});
        src1[2].push_back({1'b1, 4'h2});
        step();
        step();
        step();
        check("mid_pkt_out_valid", bus1.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", {bus1.out_valid, bus1.out_data, bus1.out_last}, 0);
        check("mid_rst_lock", {bus1.locked, bus1.in_ready}, 0);
        for (int c = 0; c < 4; c++) src1[c].delete();
        step();
        step();
        rst_n = 1'b1;
        bus1.out_ready = 1'b1;
        src1[3].push_back({1'b1, 4'h4});
        src1[0].push_back({1'b1, 4'h1});
        exp1.push_back({1'b1, 4'h1});
        exp1.push_back({1'b1, 4'h4});
        step();
        step();
        check("post_rst_first_grant", {bus1.locked, bus1.grant}, {1'b1, 2'd0});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_mux_nto1.md
# stream_mux_nto1

Parametrised, registered N-to-1 stream multiplexer with valid/ready handshake and packet-atomic channel switching. It is the sequential successor of the team's combinational 4-bit 4:1 mux. It selects among N input streams by external select or round-robin arbitration, holds a channel for a whole packet (up to `last`), and drives one registered output stage. It sits between per-channel producers and a single shared consumer.

## Interface
- `WIDTH`, 4, data bits per beat
- `N`, 4, number of input channels (N ≥ 1)
- `MODE`, 0, 0 = external select via `sel`; 1 = round-robin arbitration
- `SEL_W`, `$clog2(N)` (min 1), select/grant width
- `clk` input 1: sole clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_data` input N*WIDTH: channel i at bits [i*WIDTH +: WIDTH]
- `in_valid` input N: per-channel beat valid
- `in_last` input N: per-channel last beat of packet
- `in_ready` output N: per-channel beat accepted when `in_valid[i] && in_ready[i]`
- `sel` input SEL_W: requested channel (MODE 0 only; ignored in MODE 1)
- `out_data` output WIDTH: registered output beat
- `out_valid` output 1: output beat valid
- `out_last` output 1: output beat is last of packet
- `out_ready` input 1: consumer accepts when `out_valid && out_ready`
- `grant` output SEL_W: currently locked channel (valid while `locked` is 1)
- `locked` output 1: state is LOCKED

## Operation
- FSM states: IDLE, LOCKED. Internal `rr_ptr` (SEL_W bits), last-granted channel.
- IDLE, MODE 0: if `sel < N` and `in_valid[sel]`, set `grant <= sel`, go LOCKED. `sel ≥ N` means no grant.
- IDLE, MODE 1: scan channels `rr_ptr+1, rr_ptr+2, …` (mod N); first with `in_valid` set becomes `grant`; go LOCKED. No valid: stay IDLE.
- LOCKED: `can_load = !out_valid || out_ready`. `in_ready[i] = locked && (i == grant) && can_load`; all other `in_ready` bits are 0. In IDLE all `in_ready` are 0.
- On accepted input beat: `out_data <= in_data[grant]`, `out_last <= in_last[grant]`, `out_valid <= 1`.
- On output accept with no new input beat: `out_valid <= 0`. Data and last are held otherwise.
- Accepted input beat with `in_last[grant]=1`: `rr_ptr <= grant`, go IDLE next cycle.
- Packets never interleave. `sel` changes and other channels' `in_valid` while LOCKED are ignored.
- `in_ready` depends combinationally on `out_ready` and must not depend on any `in_valid`.
- Producers hold `in_data`/`in_last` stable while `in_valid && !in_ready`. The block does not check this.
- N=1: grant is always 0. Arbitration is trivial but the FSM is unchanged.

## Timing
- Reset (async assert, sync-safe deassert):
  - `out_valid=0`, `out_data=0`, `out_last=0`
  - `grant=0`, `locked=0`, `in_ready=0`
  - state IDLE, `rr_ptr=N-1`, so channel 0 has first priority
- Reset mid-packet drops the in-flight output beat and the lock.
- First-beat latency: `in_valid` seen in IDLE at cycle 0 → LOCKED and `in_ready` high in cycle 1 → `out_valid` high in cycle 2.
- Within a packet: one beat per cycle when `out_ready=1` (no bubbles).
- Packet switch: one IDLE cycle after each `last` beat is accepted.
- While `out_valid && !out_ready`: `out_data`, `out_last` stable; `in_ready=0`.
- Same-cycle output accept and input accept: the register is reloaded with no gap.

## Test plan
- Reset: assert `rst_n=0` mid-packet with `out_valid=1` → next observation `out_valid=0`, `out_data=0`, `locked=0`, `in_ready=4'b0000`. After release, channel 0 wins first in MODE 1.
- MODE 0, `sel=2`: ch2 valid, data 4'hA, last=1, `out_ready=1` → `in_ready=4'b0100` in cycle 1. `out_data=4'hA`, `out_last=1`, `out_valid=1` in cycle 2. Other `in_ready` bits are never high.
- MODE 1: all four channels continuously valid with single-beat packets, data = channel+1 → output sequence 1,2,3,4,1,2,…, one beat every 2 cycles.
- Packet atomicity: ch1 sends 3 beats 4'h5, 4'h6, 4'h7 (last on 7) while ch0 is valid → output 5,6,7 on consecutive cycles. Ch0 is not granted until after the IDLE cycle following beat 7.
- Backpressure: `out_ready=0` for 3 cycles with `out_valid=1`, `out_data=4'h6` → `out_data` holds 4'h6 and `in_ready=0`. Releasing `out_ready` delivers all beats in order with none lost or duplicated.
- MODE 0 edge cases:
  - `sel=3` with ch3 idle and ch0 valid → no grant, `locked=0`.
  - Changing `sel` from 2 to 0 mid-packet on ch2 → ch2 keeps the grant until its last beat.
